// File: rtl/ef_sram_bank_ctrl_if.sv
// Request/response port of the SRAM bank controller. The master drives requests,
// the slave (controller) returns responses and the sleep status.
interface ef_sram_bank_ctrl_if #(
  parameter int AW = 11
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          sleep;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, sleep
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, sleep
  );
endinterface

// File: rtl/ef_sram_bank_ctrl.sv
// SRAM bank controller tiling RAM_BLOCKS EF_SRAM_1024x32 macros with idle sleep / timed wake.
// Macros: SRAM_OUT_REG_EN adds a response register stage (read latency 2); USE_POWER_PINS exposes supplies.
module ef_sram_bank_ctrl #(
  parameter int  RAM_BLOCKS   = 2,
  parameter int  IDLE_TIMEOUT = 64,
  parameter int  WAKE_CYCLES  = 4,
  localparam int BW = (RAM_BLOCKS > 1) ? $clog2(RAM_BLOCKS) : 1,
  localparam int AW = BW + 10
) (
`ifdef USE_POWER_PINS
  inout  wire  vgnd,
  inout  wire  vnb,
  inout  wire  vpb,
  inout  wire  vpwra,
  inout  wire  vpwrac,
  inout  wire  vpwrm,
  inout  wire  vpwrp,
  inout  wire  vpwrpc,
`endif
  input  logic CLKin,
  input  logic RESETn,
  ef_sram_bank_ctrl_if.slave bus
);

  localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);
  localparam logic [WW-1:0] WAKE_MAX = WW'(WAKE_CYCLES);
  localparam logic [BW:0]   NBLK     = (BW + 1)'(RAM_BLOCKS);

  typedef enum logic [1:0] {ST_ACTIVE, ST_SLEEP, ST_WAKE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [WW-1:0] wake_q, wake_d;
  logic          accept, inflight, wloff;
  logic [BW-1:0] bank, bank_q;
  logic          oor, rd_vld_q, rd_err_q;
  logic [31:0]   ben, rd_mux;
  logic [RAM_BLOCKS-1:0] en;
  logic [31:0]   do_w        [RAM_BLOCKS];
  logic          scan_unused [RAM_BLOCKS];

  // Ready and power status depend on state only, never on req_valid.
  assign bus.req_ready = (state_q == ST_ACTIVE);
  assign bus.sleep     = (state_q == ST_SLEEP);
  assign wloff         = (state_q == ST_SLEEP);
  assign accept        = bus.req_valid & bus.req_ready;

  assign bank = bus.req_addr[AW-1:10];
  assign oor  = ({1'b0, bank} >= NBLK);
  assign ben  = {{8{bus.req_wstrb[3]}}, {8{bus.req_wstrb[2]}},
                 {8{bus.req_wstrb[1]}}, {8{bus.req_wstrb[0]}}};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLKin or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_ACTIVE;
      idle_q  <= '0;
      wake_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (accept)                 idle_d = '0;
        else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
        if ((IDLE_TIMEOUT != 0) && !accept && (idle_q == IDLE_MAX) && !inflight)
          state_d = ST_SLEEP;
      end
      ST_SLEEP: begin
        wake_d = '0;
        if (bus.req_valid) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        if (wake_q == WAKE_MAX) begin
          state_d = ST_ACTIVE;
          idle_d  = '0;
          wake_d  = '0;
        end else begin
          wake_d = wake_q + 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // Read tracking: bank and range flag are captured at accept to steer DO next cycle.
  always_ff @(posedge CLKin or negedge RESETn) begin
    if (!RESETn) begin
      bank_q   <= '0;
      rd_vld_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      rd_vld_q <= accept & ~bus.req_we;
      if (accept & ~bus.req_we) begin
        bank_q   <= bank;
        rd_err_q <= oor;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < RAM_BLOCKS; i++)
      if (bank_q == BW'(i)) rd_mux = do_w[i];
  end

`ifdef SRAM_OUT_REG_EN
  logic        rsp_vld_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  always_ff @(posedge CLKin or negedge RESETn) begin
    if (!RESETn) begin
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_vld_q   <= rd_vld_q;
      rsp_err_q   <= rd_vld_q & rd_err_q;
      rsp_rdata_q <= (rd_vld_q & ~rd_err_q) ? rd_mux : '0;
    end
  end

  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign inflight      = rd_vld_q | rsp_vld_q;
`else
  assign bus.rsp_valid = rd_vld_q;
  assign bus.rsp_err   = rd_vld_q & rd_err_q;
  assign bus.rsp_rdata = (rd_vld_q & ~rd_err_q) ? rd_mux : '0;
  assign inflight      = rd_vld_q;
`endif

  for (genvar g = 0; g < RAM_BLOCKS; g++) begin : g_bank
    localparam logic [BW-1:0] IDX = BW'(g);
    assign en[g] = accept && (bank == IDX);

    EF_SRAM_1024x32 u_sram (
`ifdef USE_POWER_PINS
      .vgnd(vgnd), .vnb(vnb), .vpb(vpb), .vpwra(vpwra), .vpwrac(vpwrac),
      .vpwrm(vpwrm), .vpwrp(vpwrp), .vpwrpc(vpwrpc),
`endif
      .DO       (do_w[g]),
      .ScanOutCC(scan_unused[g]),
      .AD       (bus.req_addr[9:0]),
      .BEN      (ben),
      .CLKin    (CLKin),
      .DI       (bus.req_wdata),
      .EN       (en[g]),
      .R_WB     (~bus.req_we),
      .ScanInCC (1'b0),
      .ScanInDL (1'b0),
      .ScanInDR (1'b0),
      .SM       (1'b0),
      .TM       (1'b0),
      .WLBI     (1'b0),
      .WLOFF    (wloff)
    );
  end

endmodule

// Behavioural stand-in for the EF_SRAM_1024x32 hard macro; replace with the
// vendor view when linking against the real macro.
module EF_SRAM_1024x32 (
`ifdef USE_POWER_PINS
  inout  wire         vgnd,
  inout  wire         vnb,
  inout  wire         vpb,
  inout  wire         vpwra,
  inout  wire         vpwrac,
  inout  wire         vpwrm,
  inout  wire         vpwrp,
  inout  wire         vpwrpc,
`endif
  output logic [31:0] DO,
  output logic        ScanOutCC,
  input  logic [9:0]  AD,
  input  logic [31:0] BEN,
  input  logic        CLKin,
  input  logic [31:0] DI,
  input  logic        EN,
  input  logic        R_WB,
  input  logic        ScanInCC,
  input  logic        ScanInDL,
  input  logic        ScanInDR,
  input  logic        SM,
  input  logic        TM,
  input  logic        WLBI,
  input  logic        WLOFF
);
  logic [31:0] mem [1024];

  assign ScanOutCC = 1'b0;
  wire unused_test = &{1'b0, ScanInCC, ScanInDL, ScanInDR, SM, TM, WLBI};
`ifdef USE_POWER_PINS
  wire unused_pwr = &{1'b0, vgnd, vnb, vpb, vpwra, vpwrac, vpwrm, vpwrp, vpwrpc};
`endif

  // NOTE: the array and DO are not reset; SRAM contents survive reset like the real macro.
  always_ff @(posedge CLKin) begin
    if (EN && !WLOFF) begin
      if (R_WB) DO <= mem[AD];
      else      mem[AD] <= (mem[AD] & ~BEN) | (DI & BEN);
    end
  end
endmodule

// File: tb/tb_ef_sram_bank_ctrl.sv
// Self-checking bench for ef_sram_bank_ctrl (3 banks, IDLE_TIMEOUT=8, WAKE_CYCLES=4):
// directed cases plus randomized traffic against a queue/array reference model.
module tb_ef_sram_bank_ctrl;
  localparam int RAM_BLOCKS   = 3;
  localparam int IDLE_TIMEOUT = 8;
  localparam int WAKE_CYCLES  = 4;
  localparam int AW           = 12;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic CLKin  = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLKin = ~CLKin;

  ef_sram_bank_ctrl_if #(.AW(AW)) bus ();

  ef_sram_bank_ctrl #(
    .RAM_BLOCKS  (RAM_BLOCKS),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .WAKE_CYCLES (WAKE_CYCLES)
  ) dut (
    .CLKin (CLKin),
    .RESETn(RESETn),
    .bus   (bus)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        exp_q [$];
  logic [31:0] mem_m [int unsigned];
  int unsigned waddr_q [$];
  int unsigned cyc;
  int          n_vec;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: word memory with byte merge; reads queue a response due LAT cycles on.
  function automatic void model_apply(input logic we, input logic [AW-1:0] a,
                                      input logic [31:0] d, input logic [3:0] s);
    int unsigned bank;
    int unsigned key;
    logic [31:0] word;
    rsp_t        r;
    bank = 32'(a[AW-1:10]);
    key  = 32'(a);
    word = mem_m.exists(key) ? mem_m[key] : 32'h0;
    if (we) begin
      if (bank < 32'(RAM_BLOCKS)) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) word[8*b +: 8] = d[8*b +: 8];
        if (!mem_m.exists(key)) waddr_q.push_back(key);
        mem_m[key] = word;
      end
    end else begin
      r.due  = cyc + LAT - 1;
      r.err  = (bank >= 32'(RAM_BLOCKS));
      r.data = r.err ? 32'h0 : word;
      exp_q.push_back(r);
    end
  endfunction

  task automatic check_rsp();
    logic exp_v;
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
    if (exp_v) begin
      check("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
      check("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
      void'(exp_q.pop_front());
    end
  endtask

  // One clock of stimulus; the master sees req_ready before the edge to know if it was taken.
  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    logic acc;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    acc = v && bus.req_ready;
    @(posedge CLKin);
    #1;
    cyc++;
    if (acc) model_apply(we, a, d, s);
    check_rsp();
    bus.req_valid = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'h1);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'h0);
    check({tag, "_sleep"}, 32'(bus.sleep), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] dir_a [4];
    int            idle_run;

    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;

    repeat (3) @(posedge CLKin);
    #1;
    check_reset_outputs("reset");
    RESETn = 1'b1;

    // Bank boundaries with 3 banks.
    dir_a = '{12'h000, 12'h3FF, 12'h400, 12'hBFF};
    foreach (dir_a[i]) cycle(1'b1, 1'b1, dir_a[i], 32'hA5A5_0000 + 32'(dir_a[i]), 4'hF);
    // Back-to-back reads over alternating banks, ready must stay high.
    dir_a = '{12'h000, 12'h400, 12'h3FF, 12'hBFF};
    foreach (dir_a[i]) begin
      cycle(1'b1, 1'b0, dir_a[i], '0, '0);
      check("ready_b2b", 32'(bus.req_ready), 32'h1);
    end
    repeat (LAT) idle();

    // Byte strobes and an all-zero strobe write.
    cycle(1'b1, 1'b1, 12'h010, 32'hFFFF_FFFF, 4'hF);
    cycle(1'b1, 1'b1, 12'h010, 32'h1234_5678, 4'b0101);
    cycle(1'b1, 1'b0, 12'h010, '0, '0);
    cycle(1'b1, 1'b1, 12'h3FF, 32'h0000_0000, 4'h0);
    cycle(1'b1, 1'b0, 12'h3FF, '0, '0);
    repeat (LAT) idle();

    // Out-of-range read errors; out-of-range write must not alias onto bank 0.
    cycle(1'b1, 1'b0, 12'hC00, '0, '0);
    cycle(1'b1, 1'b1, 12'hC00, 32'hDEAD_BEEF, 4'hF);
    cycle(1'b1, 1'b0, 12'h000, '0, '0);
    cycle(1'b1, 1'b0, 12'hFFF, '0, '0);
    repeat (LAT) idle();

    // Randomized traffic; idle runs are capped so the controller never sleeps here.
    idle_run = 0;
    for (int i = 0; i < 400; i++) begin
      logic          v, we;
      logic [AW-1:0] a;
      logic [31:0]   d;
      logic [3:0]    s;
      v  = ($urandom_range(0, 9) < 7) || (idle_run >= 5);
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      if (we) begin
        a = {2'($urandom_range(0, 3)), 10'($urandom_range(0, 31) * 33)};
        if (!mem_m.exists(32'(a))) s = 4'hF;
      end else if ($urandom_range(0, 3) == 0) begin
        a = {2'b11, 10'($urandom_range(0, 1023))};
      end else begin
        a = AW'(waddr_q[$urandom_range(0, waddr_q.size() - 1)]);
      end
      cycle(v, we, a, d, s);
      check("ready_rand", 32'(bus.req_ready), 32'h1);
      idle_run = v ? 0 : idle_run + 1;
    end
    repeat (LAT) idle();

    // Sleep entry: last accept at edge N, sleep after edge N+9.
    cycle(1'b1, 1'b1, 12'h020, 32'h0BAD_F00D, 4'hF);
    for (int k = 1; k <= 9; k++) begin
      idle();
      check("sleep_entry", 32'(bus.sleep), 32'(k == 9));
      check("ready_idle", 32'(bus.req_ready), 32'(k < 9));
    end
    repeat (3) begin
      idle();
      check("sleep_hold", 32'(bus.sleep), 32'h1);
      check("ready_sleep", 32'(bus.req_ready), 32'h0);
    end

    // Wake: req_valid held from edge M; ready returns after edge M+5, request then completes.
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b1, 1'b0, 12'h020, '0, '0);
      if (k <= 6) begin
        check("sleep_wake", 32'(bus.sleep), 32'h0);
        check("ready_wake", 32'(bus.req_ready), 32'(k == 6));
      end
    end
    repeat (LAT) idle();

    // Reset right after a read is accepted: the pending response is dropped.
    cycle(1'b1, 1'b0, 12'h400, '0, '0);
    #1;
    RESETn = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");
    repeat (2) begin
      @(posedge CLKin);
      #1;
      check("rsp_valid_in_reset", 32'(bus.rsp_valid), 32'h0);
    end
    RESETn = 1'b1;
    idle();
    cycle(1'b1, 1'b0, 12'hBFF, '0, '0);
    repeat (LAT + 1) idle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
